layer_output_writer: RTL and testbench

Packs a layer's result vector back into block RAM: latches a flat `N_WORDS*W`-bit vector on `start` and writes it one word per cycle to consecutive addresses from `BASE_ADDR`. An optional read-back pass re-reads the written region and counts mismatches. It is the write-side counterpart of the weight/bias loaders. It sits between a layer's output register and the shared BRAM port, so the next layer's loader can fetch the results.

---
 rtl/layer_output_writer.sv | 214 +++++++++++++++++++++
 tb/tb_layer_output_writer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_output_writer.sv
`default_nettype none
// ============================================================================
// Module   : layer_output_writer
// Purpose  : Latches a layer's flat N_WORDS*W result vector on start and
//            writes it, one word per cycle, to consecutive BRAM addresses
//            beginning at BASE_ADDR. With VERIFY_EN=1 the written region is
//            read back and every returning word that differs from the latched
//            copy increments mismatch_count.
// Ports    : clk, rst            clock, synchronous active-high reset
//            start, data_in      transfer request and result vector
//            bram_en/ren/wen     BRAM strobes
//            bram_addr, bram_din BRAM address and write data
//            bram_dout           BRAM read data (READ_LATENCY cycles late)
//            busy, done          status: busy outside IDLE, one-cycle done
//            mismatch_count      read-back mismatches of the last transfer
//            error               mismatch_count is non-zero
// Revision : 1.0  initial release
// ============================================================================
module layer_output_writer #(
  parameter int N_WORDS      = 8,
  parameter int W            = 8,
  parameter int ADDR_WIDTH   = 11,
  parameter int BASE_ADDR    = 1536,
  parameter int READ_LATENCY = 2,
  parameter int VERIFY_EN    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N_WORDS*W-1:0]  data_in,
  output logic                  bram_en,
  output logic                  bram_ren,
  output logic                  bram_wen,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [W-1:0]          bram_din,
  input  logic [W-1:0]          bram_dout,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   mismatch_count,
  output logic                  error
);

  localparam int                    PTR_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [PTR_W-1:0]      LAST_PTR = PTR_W'(N_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [PTR_W-1:0]        ptr, ptr_nxt;
  logic [N_WORDS*W-1:0]    shadow;
  logic                    load_shadow;
  logic                    en_nxt, ren_nxt, wen_nxt, busy_nxt, done_nxt, err_nxt;
  logic [ADDR_WIDTH-1:0]   addr_nxt;
  logic [W-1:0]            din_nxt;
  logic [ADDR_WIDTH:0]     cnt_nxt;

  // Read-return tracking: stage 0 holds the read issued in the previous
  // cycle, the last stage lines up with its data on bram_dout.
  logic [READ_LATENCY-1:0] pipe_valid;
  logic [PTR_W-1:0]        pipe_idx [READ_LATENCY];

  logic [PTR_W-1:0]        ptr_inc;
  logic [ADDR_WIDTH-1:0]   addr_inc;
  logic                    cmp_valid;
  logic [PTR_W-1:0]        cmp_idx;
  logic [W-1:0]            cmp_word;

  // ptr always names the word currently on the BRAM port, so the next
  // word/address is derived from ptr+1.
  assign ptr_inc   = ptr + PTR_W'(1);
  assign addr_inc  = BASE + ADDR_WIDTH'(ptr_inc);
  assign cmp_valid = pipe_valid[READ_LATENCY-1];
  assign cmp_idx   = pipe_idx[READ_LATENCY-1];
  assign cmp_word  = shadow[int'(cmp_idx)*W +: W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    load_shadow = 1'b0;
    en_nxt      = 1'b0;
    ren_nxt     = 1'b0;
    wen_nxt     = 1'b0;
    addr_nxt    = bram_addr;
    din_nxt     = bram_din;
    done_nxt    = 1'b0;
    cnt_nxt     = mismatch_count;
    err_nxt     = error;

    if (state == S_VERIFY && cmp_valid && cmp_word != bram_dout) begin
      cnt_nxt = mismatch_count + (ADDR_WIDTH+1)'(1);
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          // Word 0 comes straight from data_in; the shadow fills on this edge.
          load_shadow = 1'b1;
          cnt_nxt     = '0;
          err_nxt     = 1'b0;
          ptr_nxt     = '0;
          en_nxt      = 1'b1;
          wen_nxt     = 1'b1;
          addr_nxt    = BASE;
          din_nxt     = data_in[W-1:0];
          state_nxt   = S_WRITE;
        end
      end
      S_WRITE: begin
        if (ptr == LAST_PTR) begin
          if (VERIFY_EN != 0) begin
            ptr_nxt   = '0;
            en_nxt    = 1'b1;
            ren_nxt   = 1'b1;
            addr_nxt  = BASE;
            state_nxt = S_VERIFY;
          end else begin
            done_nxt  = 1'b1;
            err_nxt   = (mismatch_count != '0);
            state_nxt = S_DONE;
          end
        end else begin
          ptr_nxt  = ptr_inc;
          en_nxt   = 1'b1;
          wen_nxt  = 1'b1;
          addr_nxt = addr_inc;
          din_nxt  = shadow[int'(ptr_inc)*W +: W];
        end
      end
      S_VERIFY: begin
        if (bram_ren && ptr != LAST_PTR) begin
          ptr_nxt  = ptr_inc;
          en_nxt   = 1'b1;
          ren_nxt  = 1'b1;
          addr_nxt = addr_inc;
        end
        if (cmp_valid && cmp_idx == LAST_PTR) begin
          done_nxt  = 1'b1;
          err_nxt   = (cnt_nxt != '0);
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr            <= '0;
      shadow         <= '0;
      bram_en        <= 1'b0;
      bram_ren       <= 1'b0;
      bram_wen       <= 1'b0;
      bram_addr      <= BASE;
      bram_din       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      mismatch_count <= '0;
      error          <= 1'b0;
    end else begin
      ptr            <= ptr_nxt;
      bram_en        <= en_nxt;
      bram_ren       <= ren_nxt;
      bram_wen       <= wen_nxt;
      bram_addr      <= addr_nxt;
      bram_din       <= din_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      mismatch_count <= cnt_nxt;
      error          <= err_nxt;
      if (load_shadow) begin
        shadow <= data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_idx[i] <= '0;
      end
    end else begin
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_idx[i]   <= pipe_idx[i-1];
      end
      pipe_valid[0] <= bram_ren;
      pipe_idx[0]   <= ptr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_layer_output_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_output_writer
// Purpose  : Three writers share one stimulus stream: verify on at base 1536,
//            verify off at base 1536, and verify on at base 2044 (address
//            wrap). Each has its own BRAM model and a timeline reference
//            model derived from the transfer timing rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_layer_output_writer;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int AW = 11;
  localparam int RL = 2;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst     = 1'b1;
  logic           start   = 1'b0;
  logic [N*W-1:0] data_in = '0;
  logic           fault_on = 1'b0;

  logic [NI-1:0]  en, ren, wen, busy, done, error;
  logic [AW-1:0]  addr   [NI];
  logic [W-1:0]   din    [NI];
  logic [W-1:0]   dout   [NI];
  logic [AW:0]    mcount [NI];
  logic [W-1:0]   mem    [NI][2048];
  logic [W-1:0]   rd1    [NI];

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      layer_output_writer #(
        .N_WORDS     (N),
        .W           (W),
        .ADDR_WIDTH  (AW),
        .BASE_ADDR   ((g == 2) ? 2044 : 1536),
        .READ_LATENCY(RL),
        .VERIFY_EN   ((g == 1) ? 0 : 1)
      ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .data_in       (data_in),
        .bram_en       (en[g]),
        .bram_ren      (ren[g]),
        .bram_wen      (wen[g]),
        .bram_addr     (addr[g]),
        .bram_din      (din[g]),
        .bram_dout     (dout[g]),
        .busy          (busy[g]),
        .done          (done[g]),
        .mismatch_count(mcount[g]),
        .error         (error[g])
      );
    end
  endgenerate

  function automatic bit is_faulty(input int a);
    return fault_on && (a == 1538 || a == 1541);
  endfunction

  // BRAM models: write on en&wen, read data two cycles after the address.
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (en[g] && wen[g]) mem[g][addr[g]] <= din[g];
      rd1[g]  <= mem[g][addr[g]] ^ (is_faulty(int'(addr[g])) ? 8'hA5 : 8'h00);
      dout[g] <= rd1[g];
    end
  end

  // ---------------- reference model ----------------
  int             cyc = 0;
  bit             active    [NI];
  int             t0        [NI];
  logic [N*W-1:0] vec       [NI];
  int             exp_cnt   [NI];
  int             done_cnt  [NI];
  int             done_edge [NI];
  int             nchecks = 0;
  int             nerrors = 0;

  function automatic int base_of(input int g);
    return (g == 2) ? 2044 : 1536;
  endfunction
  function automatic bit ver_of(input int g);
    return g != 1;
  endfunction
  // Spec-cycle offset of done relative to the start edge.
  function automatic int dlat(input int g);
    return ver_of(g) ? (2*N + RL + 1) : (N + 1);
  endfunction

  task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s[%0d] cycle %0d: got 0x%0h, expected 0x%0h", name, g, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    for (int g = 0; g < NI; g++) begin
      if (rst) begin
        active[g]  = 1'b0;
        exp_cnt[g] = 0;
      end else if (start && (!active[g] || cyc - t0[g] >= dlat(g) + 1)) begin
        active[g]  = 1'b1;
        t0[g]      = cyc;
        vec[g]     = data_in;
        exp_cnt[g] = 0;
        if (ver_of(g)) begin
          for (int i = 0; i < N; i++) begin
            if (is_faulty((base_of(g) + i) % 2048)) exp_cnt[g]++;
          end
        end
      end
    end
  endtask

  task automatic model_check();
    for (int g = 0; g < NI; g++) begin
      int s;
      int d;
      bit inx, wr, rd;
      s   = cyc + 1 - t0[g];
      d   = dlat(g);
      inx = active[g] && s >= 1 && s <= d;
      wr  = inx && s <= N;
      rd  = inx && ver_of(g) && s >= N + 1 && s <= 2*N;
      chk("bram_en",  g, 32'(en[g]),   32'(wr | rd));
      chk("bram_wen", g, 32'(wen[g]),  32'(wr));
      chk("bram_ren", g, 32'(ren[g]),  32'(rd));
      chk("busy",     g, 32'(busy[g]), 32'(inx));
      chk("done",     g, 32'(done[g]), 32'(inx && s == d));
      if (wr) begin
        chk("wr_addr", g, 32'(addr[g]), 32'((base_of(g) + s - 1) % 2048));
        chk("wr_data", g, 32'(din[g]),  32'(vec[g][(s-1)*W +: W]));
      end
      if (rd) chk("rd_addr", g, 32'(addr[g]), 32'((base_of(g) + s - N - 1) % 2048));
      if (!inx || s == d) begin
        chk("mismatch_count", g, 32'(mcount[g]), exp_cnt[g]);
        chk("error",          g, 32'(error[g]),  32'(exp_cnt[g] != 0));
      end
      if (done[g]) begin
        done_cnt[g]++;
        done_edge[g] = cyc;
      end
    end
  endtask

  // One clock: model follows the edge, outputs are checked mid-cycle,
  // the caller then changes inputs.
  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    model_check();
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      step();
      n++;
    end while (busy != '0 && n < 200);
    chk("idle_reached", 0, 32'(busy), 0);
  endtask

  // Returns the edge index at which start was sampled.
  task automatic pulse(input logic [N*W-1:0] v, output int t);
    start   = 1'b1;
    data_in = v;
    step();
    t     = cyc;
    start = 1'b0;
  endtask

  initial begin
    int t;
    int c [NI];
    logic [N*W-1:0] va;

    // Reset state
    repeat (3) step();
    chk("rst_addr",   0, 32'(addr[0]),   1536);
    chk("rst_addr",   2, 32'(addr[2]),   2044);
    chk("rst_din",    0, 32'(din[0]),    0);
    chk("rst_mcount", 1, 32'(mcount[1]), 0);
    rst = 1'b0;
    step();

    // Write-only / write+verify / wrap, clean BRAM
    pulse(64'h0807060504030201, t);
    wait_idle();
    chk("wo_done_offset",  1, done_edge[1] + 1 - t, 9);
    chk("wv_done_offset",  0, done_edge[0] + 1 - t, 19);
    chk("wrp_done_offset", 2, done_edge[2] + 1 - t, 19);
    for (int i = 0; i < N; i++) chk("wo_mem", 1, 32'(mem[1][1536+i]), i + 1);
    chk("wrap_mem_2047", 2, 32'(mem[2][2047]), 4);
    chk("wrap_mem_0",    2, 32'(mem[2][0]),    5);
    chk("wv_error",      0, 32'(error[0]),  0);
    chk("wrap_error",    2, 32'(error[2]),  0);

    // Faulty read-back at 1538 and 1541
    fault_on = 1'b1;
    pulse(64'h1122334455667788, t);
    wait_idle();
    chk("fault_count", 0, 32'(mcount[0]), 2);
    chk("fault_error", 0, 32'(error[0]),  1);
    repeat (5) step();
    chk("fault_count_held", 0, 32'(mcount[0]), 2);
    chk("fault_error_held", 0, 32'(error[0]),  1);

    // start while busy is ignored
    for (int g = 0; g < NI; g++) c[g] = done_cnt[g];
    va = 64'hA1B2C3D4E5F60718;
    pulse(va, t);
    step();
    step();
    start   = 1'b1;
    data_in = 64'h5555AAAA5555AAAA;
    step();
    start = 1'b0;
    wait_idle();
    for (int g = 0; g < NI; g++) chk("busy_start_dones", g, done_cnt[g] - c[g], 1);
    for (int i = 0; i < N; i++) chk("busy_start_mem", 0, 32'(mem[0][1536+i]), 32'(va[i*W +: W]));

    // Reset mid-transfer
    for (int g = 0; g < NI; g++) c[g] = done_cnt[g];
    pulse(64'h0F0E0D0C0B0A0908, t);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_strobes", 0, 32'({en, ren, wen}), 0);
    repeat (25) step();
    for (int g = 0; g < NI; g++) chk("abort_no_done", g, done_cnt[g] - c[g], 0);
    pulse(64'h0102030405060708, t);
    wait_idle();
    for (int g = 0; g < NI; g++) chk("after_abort_done", g, done_cnt[g] - c[g], 1);

    // start held high: back-to-back restarts
    start   = 1'b1;
    data_in = {$urandom, $urandom};
    repeat (80) step();
    start = 1'b0;
    wait_idle();

    // Random starts, data and occasional resets
    for (int k = 0; k < 600; k++) begin
      start   = ($urandom_range(0, 3) == 0);
      data_in = {$urandom, $urandom};
      rst     = ($urandom_range(0, 79) == 0);
      step();
    end
    start = 1'b0;
    rst   = 1'b0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
`default_nettype wire
